// File: rtl/io_pkg.sv
// io_pkg: shared constants and helpers for the IO responder slice.
//   - Word indices of the IO register map (address bits [5:2]).
//   - Bit positions inside the UART status word.
//   - Address bit that selects the IO page.
//   - pack_status(): assembles the UART status word from its fields.
package io_pkg;

  typedef logic [3:0] word_idx_t;

  localparam int IO_PAGE_BIT = 22;

  localparam word_idx_t IO_LEDS        = 4'd0;
  localparam word_idx_t IO_UART_DATA   = 4'd1;
  localparam word_idx_t IO_UART_STATUS = 4'd2;
  localparam word_idx_t IO_TIMER       = 4'd3;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 8;

  // Status word layout: busy/full/overflow flags plus the 8-bit FIFO count.
  function automatic logic [31:0] pack_status(input logic busy, input logic full,
                                              input logic ovf, input logic [7:0] cnt);
    logic [31:0] w;
    w                   = 32'h0000_0000;
    w[ST_BUSY]          = busy;
    w[ST_FULL]          = full;
    w[ST_OVF]           = ovf;
    w[ST_CNT_LSB +: 8]  = cnt;
    return w;
  endfunction

endpackage

// File: rtl/io_responder_uart_tx_shifter.sv
// uart_tx_shifter: 8N1 UART transmitter fed from a byte FIFO.
//   clk     in   system clock
//   reset   in   asynchronous active-high reset (txd forced high)
//   tx_byte in   byte at the FIFO head
//   valid   in   FIFO non-empty
//   ready   out  pop strobe: the head byte is consumed at the next edge
//   txd     out  serial line, idle high
//   active  out  a frame is in progress
// Each bit lasts DIV cycles. When the stop bit ends and another byte is
// waiting, the next start bit follows with no idle gap.
module uart_tx_shifter #(
  parameter int DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_byte,
  input  logic       valid,
  output logic       ready,
  output logic       txd,
  output logic       active
);

  localparam int CW = $clog2(DIV);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    state_r;
  logic [CW-1:0] baud_cnt_r;
  logic [2:0]    bit_cnt_r;
  logic [7:0]    shreg_r;
  logic          txd_r;
  logic          baud_last_s;

  assign baud_last_s = (baud_cnt_r == CW'(DIV - 1));
  // A byte is taken either from idle or in the final cycle of a stop bit.
  assign ready  = valid & ((state_r == S_IDLE) | ((state_r == S_STOP) & baud_last_s));
  assign txd    = txd_r;
  assign active = (state_r != S_IDLE);

  // Frame sequencer: start bit, eight data bits LSB first, stop bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= S_IDLE;
      baud_cnt_r <= {CW{1'b0}};
      bit_cnt_r  <= 3'd0;
      shreg_r    <= 8'h00;
      txd_r      <= 1'b1;
    end else begin
      case (state_r)
        S_IDLE: begin
          baud_cnt_r <= {CW{1'b0}};
          if (valid) begin
            state_r <= S_START;
            shreg_r <= tx_byte;
            txd_r   <= 1'b0;
          end else begin
            txd_r   <= 1'b1;
          end
        end
        S_START: begin
          if (baud_last_s) begin
            state_r    <= S_DATA;
            bit_cnt_r  <= 3'd0;
            baud_cnt_r <= {CW{1'b0}};
            txd_r      <= shreg_r[0];
            shreg_r    <= {1'b0, shreg_r[7:1]};
          end else begin
            baud_cnt_r <= baud_cnt_r + CW'(1);
          end
        end
        S_DATA: begin
          if (baud_last_s) begin
            baud_cnt_r <= {CW{1'b0}};
            if (bit_cnt_r == 3'd7) begin
              state_r <= S_STOP;
              txd_r   <= 1'b1;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
              txd_r     <= shreg_r[0];
              shreg_r   <= {1'b0, shreg_r[7:1]};
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CW'(1);
          end
        end
        S_STOP: begin
          if (baud_last_s) begin
            baud_cnt_r <= {CW{1'b0}};
            if (valid) begin
              state_r <= S_START;
              shreg_r <= tx_byte;
              txd_r   <= 1'b0;
            end else begin
              state_r <= S_IDLE;
              txd_r   <= 1'b1;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CW'(1);
          end
        end
        default: begin
          state_r    <= S_IDLE;
          baud_cnt_r <= {CW{1'b0}};
          txd_r      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/io_responder.sv
// io_responder: memory-mapped IO target on the core's IO port.
//   clk           in   system clock
//   reset         in   asynchronous active-high reset
//   IO_mem_addr   in   byte address; bit 22 selects the IO page, [5:2] word
//   IO_mem_wdata  in   write data
//   IO_mem_wr     in   one-cycle write strobe
//   IO_mem_rdata  out  read data, combinational from address and state
//   leds          out  LED register
//   uart_txd      out  UART serial output, idle high
// Register map: 0 LEDS (R/W), 1 UART_DATA (W, pushes a byte),
// 2 UART_STATUS (R; write with bit2 set clears overflow), 3 TIMER (R).
module io_responder
  import io_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 8,
  parameter int LED_W       = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      IO_mem_addr,
  input  logic [31:0]      IO_mem_wdata,
  input  logic             IO_mem_wr,
  output logic [31:0]      IO_mem_rdata,
  output logic [LED_W-1:0] leds,
  output logic             uart_txd
);

  localparam int DIV_C = CLK_FREQ_HZ / BAUD;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNTW  = AW + 1;

  if (DIV_C < 2) begin : g_bad_div
    $error("io_responder: CLK_FREQ_HZ/BAUD must be at least 2");
  end
  if ((FIFO_DEPTH < 2) || (FIFO_DEPTH > 256) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("io_responder: FIFO_DEPTH must be a power of two in 2..256");
  end
  if ((LED_W < 1) || (LED_W > 32)) begin : g_bad_led_w
    $error("io_responder: LED_W must be in 1..32");
  end

  logic             sel_s;
  word_idx_t        idx_s;
  logic             wr_en_s;
  logic             push_req_s;
  logic             push_ok_s;
  logic             pop_s;
  logic             ovf_set_s;
  logic             ovf_clr_s;
  logic             fifo_valid_s;
  logic             full_s;
  logic             tx_active_s;
  logic [31:0]      rdata_s;
  logic             unused_s;

  logic [LED_W-1:0] leds_r;
  logic [31:0]      timer_r;
  logic             ovf_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CNTW-1:0]  count_r;
  logic [7:0]       fifo_mem_r [FIFO_DEPTH];

  assign sel_s        = IO_mem_addr[IO_PAGE_BIT];
  assign idx_s        = IO_mem_addr[5:2];
  assign wr_en_s      = IO_mem_wr & sel_s;
  assign push_req_s   = wr_en_s & (idx_s == IO_UART_DATA);
  assign ovf_clr_s    = wr_en_s & (idx_s == IO_UART_STATUS) & IO_mem_wdata[ST_OVF];
  assign fifo_valid_s = (count_r != {CNTW{1'b0}});
  assign full_s       = (count_r == CNTW'(FIFO_DEPTH));
  // A full FIFO still takes a byte when the shifter pops in the same cycle.
  assign push_ok_s    = push_req_s & (~full_s | pop_s);
  assign ovf_set_s    = push_req_s & ~push_ok_s;

  // Address bits outside the decode and data bits no register keeps.
  assign unused_s = ^{IO_mem_addr[31:23], IO_mem_addr[21:6], IO_mem_addr[1:0], IO_mem_wdata};

  // LED register, loaded by writes to word 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds_r <= {LED_W{1'b0}};
    end else if (wr_en_s && (idx_s == IO_LEDS)) begin
      leds_r <= IO_mem_wdata[LED_W-1:0];
    end else begin
      leds_r <= leds_r;
    end
  end

  // Free-running cycle timer, wraps naturally at 32 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_r <= 32'h0000_0000;
    end else begin
      timer_r <= timer_r + 32'd1;
    end
  end

  // Sticky overflow flag; a dropped byte takes priority over a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_r <= 1'b0;
    end else if (ovf_set_s) begin
      ovf_r <= 1'b1;
    end else if (ovf_clr_s) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      fifo_mem_r[wr_ptr_r] <= IO_mem_wdata[7:0];
    end
  end

  // FIFO pointers and occupancy; pointers wrap modulo the power-of-two depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CNTW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      if (push_ok_s && !pop_s) begin
        count_r <= count_r + CNTW'(1);
      end else if (pop_s && !push_ok_s) begin
        count_r <= count_r - CNTW'(1);
      end else begin
        count_r <= count_r;
      end
    end
  end

  uart_tx_shifter #(
    .DIV (DIV_C)
  ) u_tx (
    .clk     (clk),
    .reset   (reset),
    .tx_byte (fifo_mem_r[rd_ptr_r]),
    .valid   (fifo_valid_s),
    .ready   (pop_s),
    .txd     (uart_txd),
    .active  (tx_active_s)
  );

  // Read mux: the core samples it in the same cycle, so no side effects.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (sel_s) begin
      case (idx_s)
        IO_LEDS:        rdata_s = 32'(leds_r);
        IO_UART_STATUS: rdata_s = pack_status(fifo_valid_s | tx_active_s, full_s, ovf_r, 8'(count_r));
        IO_TIMER:       rdata_s = timer_r;
        default:        rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  assign IO_mem_rdata = rdata_s;
  assign leds         = leds_r;

endmodule

// File: tb/tb_io_responder.sv
// Self-checking bench for io_responder with DIV=10 and an 8-deep FIFO.
// The reference model keeps the FIFO as a queue and the line as a frame
// position counter; txd is derived from position/DIV.
module tb_io_responder;

  localparam int CLK_FREQ_HZ = 1000;
  localparam int BAUD        = 100;
  localparam int FIFO_DEPTH  = 8;
  localparam int LED_W       = 5;
  localparam int DIV         = CLK_FREQ_HZ / BAUD;
  localparam int FRAME       = 10 * DIV;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      IO_mem_addr;
  logic [31:0]      IO_mem_wdata;
  logic             IO_mem_wr;
  logic [31:0]      IO_mem_rdata;
  logic [LED_W-1:0] leds;
  logic             uart_txd;

  int tests_run    = 0;
  int tests_failed = 0;

  // reference model state
  logic [7:0]       m_q[$];
  logic             m_ovf;
  logic [LED_W-1:0] m_leds;
  logic [31:0]      m_timer;
  bit               m_tx_on;
  int               m_tx_pos;
  logic [7:0]       m_tx_byte;

  io_responder #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .BAUD        (BAUD),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .LED_W       (LED_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .IO_mem_addr  (IO_mem_addr),
    .IO_mem_wdata (IO_mem_wdata),
    .IO_mem_wr    (IO_mem_wr),
    .IO_mem_rdata (IO_mem_rdata),
    .leds         (leds),
    .uart_txd     (uart_txd)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf     = 1'b0;
    m_leds    = '0;
    m_timer   = 32'd0;
    m_tx_on   = 1'b0;
    m_tx_pos  = 0;
    m_tx_byte = 8'h00;
  endtask

  function automatic logic m_txd();
    int b;
    if (!m_tx_on) return 1'b1;
    b = m_tx_pos / DIV;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_tx_byte[b-1];
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic busy;
    logic full;
    if (!a[22]) return 32'd0;
    busy = (m_q.size() > 0) || m_tx_on;
    full = (m_q.size() == FIFO_DEPTH);
    case (a[5:2])
      4'd0:    return 32'(m_leds);
      4'd2:    return {16'h0000, 8'(m_q.size()), 5'b00000, m_ovf, full, busy};
      4'd3:    return m_timer;
      default: return 32'd0;
    endcase
  endfunction

  // Apply one clock edge to the model using the inputs of the ending cycle.
  task automatic model_edge();
    bit         wr_ok;
    logic [3:0] idx;
    int         sz0;
    bit         pop;
    bit         ovf_set;
    logic [7:0] popped;
    wr_ok   = IO_mem_wr && IO_mem_addr[22];
    idx     = IO_mem_addr[5:2];
    sz0     = m_q.size();
    pop     = 1'b0;
    ovf_set = 1'b0;
    popped  = 8'h00;
    if (sz0 > 0 && (!m_tx_on || m_tx_pos == FRAME - 1)) begin
      pop    = 1'b1;
      popped = m_q.pop_front();
    end
    if (wr_ok && idx == 4'd1) begin
      if (sz0 < FIFO_DEPTH || pop) m_q.push_back(IO_mem_wdata[7:0]);
      else ovf_set = 1'b1;
    end
    if (wr_ok && idx == 4'd0) m_leds = IO_mem_wdata[LED_W-1:0];
    if (ovf_set) m_ovf = 1'b1;
    else if (wr_ok && idx == 4'd2 && IO_mem_wdata[2]) m_ovf = 1'b0;
    if (pop) begin
      m_tx_on   = 1'b1;
      m_tx_pos  = 0;
      m_tx_byte = popped;
    end else if (m_tx_on) begin
      if (m_tx_pos == FRAME - 1) m_tx_on = 1'b0;
      else m_tx_pos++;
    end
    m_timer = m_timer + 32'd1;
  endtask

  // Set bus inputs for the current cycle and check the combinational read.
  task automatic drive(input logic [31:0] a, input logic wr, input logic [31:0] wd);
    IO_mem_addr  = a;
    IO_mem_wr    = wr;
    IO_mem_wdata = wd;
    #1;
    check_eq("rdata", IO_mem_rdata, model_read(a));
  endtask

  // Advance one edge and compare the registered outputs with the model.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("txd", 32'(uart_txd), 32'(m_txd()));
    check_eq("leds", 32'(leds), 32'(m_leds));
  endtask

  task automatic cycle(input logic [31:0] a, input logic wr, input logic [31:0] wd);
    drive(a, wr, wd);
    tick();
  endtask

  initial begin
    logic [31:0] a;
    reset        = 1'b1;
    IO_mem_addr  = 32'd0;
    IO_mem_wr    = 1'b0;
    IO_mem_wdata = 32'd0;
    model_reset();

    // reset state of every mapped word and the line
    for (int i = 0; i < 4; i++) begin
      IO_mem_addr = 32'h0040_0000 + 32'(4 * i);
      #1;
      check_eq("reset_word", IO_mem_rdata, 32'd0);
    end
    check_eq("reset_txd", 32'(uart_txd), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // LED register
    cycle(32'h0040_0000, 1'b1, 32'h0000_001F);
    check_eq("leds_1f", 32'(leds), 32'h1F);
    drive(32'h0040_0000, 1'b0, 32'd0);
    check_eq("rd_leds_1f", IO_mem_rdata, 32'h1F);
    drive(32'h0000_0000, 1'b0, 32'd0);
    check_eq("rd_nosel", IO_mem_rdata, 32'd0);
    tick();
    cycle(32'h0040_0000, 1'b1, 32'hFFFF_FFE0);
    check_eq("leds_0", 32'(leds), 32'h0);

    // single frame 0x55
    cycle(32'h0040_0004, 1'b1, 32'h0000_0055);
    for (int i = 0; i < FRAME + 5; i++) cycle(32'h0040_0008, 1'b0, 32'd0);
    drive(32'h0040_0008, 1'b0, 32'd0);
    check_eq("frame_done_status", IO_mem_rdata, 32'd0);
    tick();

    // two frames back to back
    cycle(32'h0040_0004, 1'b1, 32'h0000_00A3);
    cycle(32'h0040_0004, 1'b1, 32'h0000_000F);
    drive(32'h0040_0008, 1'b0, 32'd0);
    check_eq("b2b_count1", IO_mem_rdata, 32'h0000_0101);
    tick();
    for (int i = 0; i < 2 * FRAME + 5; i++) cycle(32'h0040_0008, 1'b0, 32'd0);

    // overflow while the shifter is busy
    cycle(32'h0040_0004, 1'b1, 32'h0000_0011);
    for (int i = 0; i < 3; i++) cycle(32'h0040_0008, 1'b0, 32'd0);
    for (int i = 0; i <= FIFO_DEPTH; i++) cycle(32'h0040_0004, 1'b1, 32'h20 + 32'(i));
    drive(32'h0040_0008, 1'b0, 32'd0);
    check_eq("ovf_status", IO_mem_rdata, 32'h0000_0807);
    tick();
    cycle(32'h0040_0008, 1'b1, 32'h0000_0004);
    drive(32'h0040_0008, 1'b0, 32'd0);
    check_eq("ovf_cleared", IO_mem_rdata, 32'h0000_0803);
    tick();
    for (int i = 0; i < (FIFO_DEPTH + 1) * FRAME + 10; i++) cycle(32'h0040_0008, 1'b0, 32'd0);

    // reset in the middle of a data bit
    cycle(32'h0040_0004, 1'b1, 32'h0000_00C3);
    for (int i = 0; i < 25; i++) cycle(32'h0040_0008, 1'b0, 32'd0);
    drive(32'h0040_0008, 1'b0, 32'd0);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check_eq("midreset_txd", 32'(uart_txd), 32'd1);
    check_eq("midreset_status", IO_mem_rdata, 32'd0);
    #1;
    reset = 1'b0;
    drive(32'h0040_000C, 1'b0, 32'd0);
    check_eq("timer_0", IO_mem_rdata, 32'd0);
    tick();
    drive(32'h0040_000C, 1'b0, 32'd0);
    check_eq("timer_1", IO_mem_rdata, 32'd1);
    tick();
    drive(32'h0040_000C, 1'b0, 32'd0);
    check_eq("timer_2", IO_mem_rdata, 32'd2);
    tick();

    // randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      a      = $urandom;
      a[22]  = ($urandom_range(0, 3) != 0);
      a[5:2] = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(4, 15));
      cycle(a, ($urandom_range(0, 6) == 0), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
